// File: rtl/slider_switch_debouncer_if.sv
// Signal bundle between the raw slide-switch pins and the PIO-facing debounced outputs.
// The master drives the pins; the slave is the debouncer that conditions them.
interface slider_switch_debouncer_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] sw_raw;
    logic [WIDTH-1:0] sw_clean;
    logic [WIDTH-1:0] sw_changed;
    logic [WIDTH-1:0] sw_rise;
    logic             any_change;

    modport master (
        output sw_raw,
        input  sw_clean,
        input  sw_changed,
        input  sw_rise,
        input  any_change
    );

    modport slave (
        input  sw_raw,
        output sw_clean,
        output sw_changed,
        output sw_rise,
        output any_change
    );
endinterface

// File: rtl/slider_switch_debouncer.sv
// Per-bit two-flop synchroniser and bounce filter for slide switches.
// Outputs a stable level plus one-cycle change and rise strobes.
module slider_switch_debouncer #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic                      clk,
    input  logic                      reset_n,
    slider_switch_debouncer_if.slave  sw
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] clean_q;
    logic [WIDTH-1:0] changed_q;
    logic [WIDTH-1:0] rise_q;
    logic [CNT_W-1:0] cnt [WIDTH];

    logic [WIDTH-1:0] mismatch;
    logic [WIDTH-1:0] at_limit;

    // NOTE: sequential state uses <= so every flop samples pre-edge values; with = the
    // second stage would see sync1's new value and collapse the synchroniser to one flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= sw.sw_raw;
            sync2 <= sync1;
        end
    end

    // NOTE: every output of an always_comb is given a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        mismatch = sync2 ^ clean_q;
        at_limit = '0;
        for (int i = 0; i < WIDTH; i++) begin
            at_limit[i] = (cnt[i] == CNT_LAST);
        end
    end

    // A new level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples;
    // any agreement in between clears the count, so bounces earn no partial credit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the counter array is reset along with everything else so a reset in
            // mid-count cannot leave stale credit toward the next acceptance.
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
            clean_q   <= '0;
            changed_q <= '0;
            rise_q    <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                changed_q[i] <= 1'b0;
                rise_q[i]    <= 1'b0;
                if (!mismatch[i]) begin
                    cnt[i] <= '0;
                end else if (!at_limit[i]) begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end else begin
                    cnt[i]       <= '0;
                    clean_q[i]   <= sync2[i];
                    changed_q[i] <= 1'b1;
                    rise_q[i]    <= sync2[i];
                end
            end
        end
    end

    assign sw.sw_clean   = clean_q;
    assign sw.sw_changed = changed_q;
    assign sw.sw_rise    = rise_q;
    assign sw.any_change = |changed_q;
endmodule

// File: doc/slider_switch_debouncer.md
Name: slider_switch_debouncer

Overview:
- Conditions raw slide-switch pins before they reach the slider-switch PIO input port.
- Synchronises each asynchronous pin into the system clock domain and filters contact bounce per bit.
- Presents a stable vector on sw_clean, which drives the PIO in_port directly.
- Also emits per-bit one-cycle change and rise strobes for an optional edge-capture or IRQ consumer.

Parameters:
- WIDTH, 4, number of switch bits.
- DEBOUNCE_CYCLES, 1000000, consecutive clk cycles a new level must persist before acceptance (20 ms at 50 MHz); legal range 1 .. 2^CNT_W-1.
- CNT_W, 20, width of each per-bit stability counter.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- sw_raw  input  WIDTH  raw switch pins; asynchronous to clk and bouncy.
- sw_clean  output  WIDTH  debounced switch state; feeds the PIO in_port.
- sw_changed  output  WIDTH  one-cycle strobe per bit when sw_clean[i] toggles.
- sw_rise  output  WIDTH  one-cycle strobe per bit when sw_clean[i] goes 0->1.
- any_change  output  1  OR-reduction of sw_changed.

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low. Every register is cleared on reset assertion: sync stages, counters, sw_clean, sw_changed and sw_rise all go to 0, so any_change is 0.
- Synchroniser: each bit passes through two flops, sync1 then sync2. Only sync2 is used downstream. No logic sits between the two stages.
- Per-bit filter, evaluated at each clk edge:
  - sync2[i] == sw_clean[i]: cnt[i] <= 0; sw_clean[i] holds.
  - sync2[i] != sw_clean[i] and cnt[i] != DEBOUNCE_CYCLES-1: cnt[i] <= cnt[i]+1.
  - sync2[i] != sw_clean[i] and cnt[i] == DEBOUNCE_CYCLES-1: sw_clean[i] <= sync2[i]; cnt[i] <= 0; sw_changed[i] <= 1.
  - sw_changed[i] is 0 on every other edge.
- Rise and change strobes:
  - sw_rise[i] <= 1 only on an update edge where the new value is 1.
  - any_change is the combinational OR of the registered sw_changed.
- Latency: label as edge 0 the first clk edge that samples a new stable sw_raw level. sw_clean updates on edge DEBOUNCE_CYCLES+1, and the strobe is high for exactly the following cycle.
- Glitch rejection: a mismatch that lasts fewer than DEBOUNCE_CYCLES consecutive sync2 samples never reaches sw_clean. Any return to agreement clears cnt, so there is no partial credit across bounces.
- Independence: bits are filtered independently. Several bits may update, and strobe, on the same edge.
- DEBOUNCE_CYCLES == 1: no filtering. sw_clean tracks sync2 with one cycle of delay.
- Counter width: cnt never exceeds DEBOUNCE_CYCLES-1, so it cannot wrap.
- Reset mid-count: all counts are lost, and filtering restarts from sw_clean = 0.
- Switches already high at reset release: they are accepted after DEBOUNCE_CYCLES+2 edges, with a sw_changed and sw_rise strobe. This start-up strobe is intended behaviour.
- Structure: no combinational path from sw_raw to any output. Every output is registered except any_change.

Test Plan (DEBOUNCE_CYCLES=8, CNT_W=4, WIDTH=4):
- Reset with sw_raw=4'hF held -> all outputs 0 during reset. After release, sw_clean=4'hF on edge 9 (edge 0 = first post-reset sampling edge); sw_changed=sw_rise=4'hF and any_change=1 for one cycle only.
- sw_raw[0] 0->1 held -> sw_clean[0]=1 on edge 9 after the change; sw_changed[0] and sw_rise[0] pulse one cycle; bits 3:1 unchanged with no strobes.
- Bounce on bit 1: pattern 1,0,1,1,0 (one cycle each), then held 1 -> sw_clean[1] stays 0 until 8 consecutive 1 samples at sync2, then goes to 1; exactly one strobe.
- Glitch: sw_raw[2] high for 7 cycles, then low -> sw_clean[2] never changes; sw_changed stays 4'h0.
- Bit 3 falls 1->0 while bit 0 rises, simultaneously and held -> both update on the same edge; sw_changed=4'h9, sw_rise=4'h1.
- reset_n pulsed low while bit 2 is at count 5 -> all outputs 0 immediately (asynchronous). With sw_raw[2]=1 held, the bit is re-accepted a full 9 edges after release.
